// File: rtl/regfile_write_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_queue_pkg
//  Description : Shared register-file types and the register-ID to wordline
//                decoder used by both the read and write ports.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_write_queue_pkg;

    localparam int REG_ID_W = 4;
    localparam int NUM_REGS = 16;
    localparam int RF_DW    = 16;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [NUM_REGS-1:0] wordline_t;

    typedef struct packed {
        reg_id_t          reg_id;
        logic [RF_DW-1:0] data;
    } rf_entry_t;

    // One-hot wordline for a register ID; IDs 0 and 15 need no special case.
    function automatic wordline_t decode_wordline(input reg_id_t id);
        wordline_t w_wl;
        w_wl     = '0;
        w_wl[id] = 1'b1;
        return w_wl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_queue_if
//  Description : Write-back request, array write port and forwarding lookup
//                signals of the register-file write queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
);
    import regfile_write_queue_pkg::*;

    // Write-back side
    logic                     wr_req;
    reg_id_t                  wr_reg;
    logic [DW-1:0]            wr_data;
    logic                     wr_ready;
    // Register array side
    logic                     rf_ready;
    logic                     WriteEnable;
    wordline_t                WriteWordline;
    logic [DW-1:0]            WriteData;
    // Forwarding lookup
    reg_id_t                  rd_reg;
    logic                     fwd_hit;
    logic [DW-1:0]            fwd_data;
    // Status
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output wr_req, wr_reg, wr_data, rf_ready, rd_reg,
        input  wr_ready, WriteEnable, WriteWordline, WriteData,
               fwd_hit, fwd_data, count
    );

    modport slave (
        input  wr_req, wr_reg, wr_data, rf_ready, rd_reg,
        output wr_ready, WriteEnable, WriteWordline, WriteData,
               fwd_hit, fwd_data, count
    );

endinterface
`default_nettype wire

// File: rtl/regfile_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_fwd_match
//  Description : DEPTH-way compare of a read register ID against pending
//                queue entries, returning hit and the youngest matching data.
//                Entries arrive age-ordered: index 0 is oldest (head).
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_fwd_match
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  reg_id_t                   rd_reg,
    input  rf_entry_t [DEPTH-1:0]     entries,
    input  logic      [DEPTH-1:0]     valid,
    output logic                      hit,
    output logic      [RF_DW-1:0]     data
);

    // Scan oldest to youngest so the last (youngest) match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].reg_id == rd_reg)) begin
                hit  = 1'b1;
                data = entries[i].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_queue
//  Description : In-order write-back queue in front of the register array.
//                Drives one one-hot write wordline plus data per cycle and
//                offers a forwarding lookup over pending writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_write_queue_if.slave   bus
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam int               CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    rf_entry_t              r_mem [DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    rf_entry_t              w_head;
    rf_entry_t [DEPTH-1:0]  w_age_entry;
    logic [DEPTH-1:0]       w_age_valid;
    logic                   w_fwd_hit;
    logic [RF_DW-1:0]       w_fwd_data;

    // Full/empty come from the occupancy counter, never pointer equality.
    // Full refuses pushes even when a pop happens in the same cycle.
    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.wr_req & ~w_full;
    assign w_pop   = ~w_empty & bus.rf_ready;
    assign w_head  = r_mem[r_head];

    assign bus.wr_ready      = ~w_full;
    assign bus.WriteEnable   = ~w_empty;
    assign bus.WriteWordline = w_empty ? '0 : decode_wordline(w_head.reg_id);
    assign bus.WriteData     = w_empty ? '0 : DW'(w_head.data);
    assign bus.count         = r_count;

    // Present the entries oldest-first so the matcher can pick the youngest.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [PTR_W-1:0] w_idx;
        assign w_idx           = r_head + PTR_W'(gi);
        assign w_age_entry[gi] = r_mem[w_idx];
        assign w_age_valid[gi] = (CNT_W'(gi) < r_count);
    end

    regfile_fwd_match #(
        .DEPTH   (DEPTH)
    ) u_fwd_match (
        .rd_reg  (bus.rd_reg),
        .entries (w_age_entry),
        .valid   (w_age_valid),
        .hit     (w_fwd_hit),
        .data    (w_fwd_data)
    );

    assign bus.fwd_hit  = w_fwd_hit;
    assign bus.fwd_data = DW'(w_fwd_data);

    // Pointers and occupancy; reset discards every entry in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents outside the valid range are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail].reg_id <= bus.wr_reg;
            r_mem[r_tail].data   <= RF_DW'(bus.wr_data);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_queue
//  Description : Directed self-checking bench for regfile_write_queue with a
//                scoreboard of pushed writes compared as they are popped.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_queue;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_write_queue_if #(.DEPTH(DEPTH), .DW(16)) bus();

    regfile_write_queue #(.DEPTH(DEPTH), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  id;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   ids[10] = '{0, 15, 3, 8, 1, 14, 7, 9, 12, 15};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model the pop/push about to happen, take the edge, check occupancy.
    task automatic step(input string tag);
        exp_t e;
        int   sz;
        sz = sb.size();
        check({tag, " wr_ready"}, 32'(bus.wr_ready), 32'(sz < DEPTH));
        if (sz != 0 && bus.rf_ready) begin
            e = sb.pop_front();
            check({tag, " wordline"}, 32'(bus.WriteWordline), 32'(16'd1 << e.id));
            check({tag, " wdata"}, 32'(bus.WriteData), 32'(e.data));
        end
        if (bus.wr_req && sz < DEPTH) begin
            e.id   = bus.wr_reg;
            e.data = bus.wr_data;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, " count"}, 32'(bus.count), 32'(sb.size()));
        check({tag, " wen"}, 32'(bus.WriteEnable), 32'(sb.size() != 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] wl_exp;

        // Reset then idle
        rst          = 1'b1;
        bus.wr_req   = 1'b0;
        bus.wr_reg   = '0;
        bus.wr_data  = '0;
        bus.rf_ready = 1'b0;
        bus.rd_reg   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst wen",      32'(bus.WriteEnable),   32'd0);
        check("rst wordline", 32'(bus.WriteWordline), 32'h0000);
        check("rst wdata",    32'(bus.WriteData),     32'd0);
        check("rst wr_ready", 32'(bus.wr_ready),      32'd1);
        check("rst count",    32'(bus.count),         32'd0);
        check("rst fwd_hit",  32'(bus.fwd_hit),       32'd0);
        check("rst fwd_data", 32'(bus.fwd_data),      32'd0);

        // Single write
        bus.wr_req   = 1'b1;
        bus.wr_reg   = 4'd5;
        bus.wr_data  = 16'hBEEF;
        bus.rf_ready = 1'b1;
        step("single push");
        bus.wr_req = 1'b0;
        check("single wordline", 32'(bus.WriteWordline), 32'h0020);
        check("single wdata",    32'(bus.WriteData),     32'hBEEF);
        step("single pop");
        check("single empty wen", 32'(bus.WriteEnable), 32'd0);
        check("single empty wl",  32'(bus.WriteWordline), 32'h0000);

        // Fill with back-pressure, then a dropped fifth push
        bus.rf_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.wr_req  = 1'b1;
            bus.wr_reg  = 4'(i);
            bus.wr_data = 16'hA000 + 16'(i);
            step("fill");
        end
        check("full count",    32'(bus.count),    32'd4);
        check("full wr_ready", 32'(bus.wr_ready), 32'd0);
        bus.wr_reg  = 4'd9;
        bus.wr_data = 16'h9999;
        step("dropped push");
        bus.wr_req = 1'b0;
        check("dropped count", 32'(bus.count), 32'd4);
        bus.rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wl_exp = 16'h0002 << i;
            check("drain order wl", 32'(bus.WriteWordline), 32'(wl_exp));
            step("drain");
        end
        check("drain empty wen", 32'(bus.WriteEnable), 32'd0);

        // Push and pop while full: pop happens, push refused
        bus.rf_ready = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            bus.wr_req  = 1'b1;
            bus.wr_reg  = 4'(i);
            bus.wr_data = 16'hB000 + 16'(i);
            step("refill");
        end
        bus.rf_ready = 1'b1;
        bus.wr_reg   = 4'd14;
        bus.wr_data  = 16'hEEEE;
        check("full pp wr_ready", 32'(bus.wr_ready), 32'd0);
        step("full push+pop");
        bus.wr_req = 1'b0;
        check("full pp count", 32'(bus.count), 32'd3);
        repeat (3) step("drain2");

        // Forwarding
        bus.rf_ready = 1'b0;
        bus.rd_reg   = 4'd6;
        bus.wr_req   = 1'b1;
        bus.wr_reg   = 4'd6;
        bus.wr_data  = 16'h6666;
        #1;
        check("fwd same-cycle push hidden", 32'(bus.fwd_hit), 32'd0);
        step("fwd push6");
        bus.wr_reg  = 4'd7;
        bus.wr_data = 16'h1111;
        step("fwd push7a");
        bus.wr_data = 16'h2222;
        step("fwd push7b");
        bus.wr_req = 1'b0;
        bus.rd_reg = 4'd7;
        #1;
        check("fwd r7 hit",  32'(bus.fwd_hit),  32'd1);
        check("fwd r7 data", 32'(bus.fwd_data), 32'h2222);
        bus.rd_reg = 4'd8;
        #1;
        check("fwd r8 hit",  32'(bus.fwd_hit),  32'd0);
        check("fwd r8 data", 32'(bus.fwd_data), 32'd0);
        bus.rd_reg   = 4'd6;
        bus.rf_ready = 1'b1;
        #1;
        check("fwd popping hit",  32'(bus.fwd_hit),  32'd1);
        check("fwd popping data", 32'(bus.fwd_data), 32'h6666);
        bus.rf_ready = 1'b0;
        #1;

        // Reset while holding three entries
        check("pre-rst count", 32'(bus.count), 32'd3);
        rst = 1'b1;
        #1;
        sb.delete();
        check("mid-rst count",    32'(bus.count),         32'd0);
        check("mid-rst wordline", 32'(bus.WriteWordline), 32'h0000);
        check("mid-rst wen",      32'(bus.WriteEnable),   32'd0);
        check("mid-rst fwd_hit",  32'(bus.fwd_hit),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Wrap-around: sustained push/pop pairs across pointer wrap
        bus.rf_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.wr_req  = 1'b1;
            bus.wr_reg  = 4'(ids[k]);
            bus.wr_data = 16'h5A00 + 16'(k);
            step("wrap");
            check("wrap onehot", 32'($onehot(bus.WriteWordline)), 32'd1);
        end
        bus.wr_req = 1'b0;
        repeat (2) step("wrap drain");
        check("final count", 32'(bus.count),       32'd0);
        check("final wen",   32'(bus.WriteEnable), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_queue.md
# regfile_write_queue

Write-side companion to the register file's 4-to-16 read wordline decoder. Buffers register write-back requests in a 4-entry in-order queue, drives one one-hot 16-bit write wordline plus data into the register array per cycle, and exposes a forwarding lookup so the read side can see pending writes. It sits between the write-back stage and the register array.

## Interface
- DEPTH, 4, queue entries; power of two, 2..8.
- DW, 16, data width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_req  in  1  write-back request valid.
- wr_reg  in  4  destination register ID.
- wr_data  in  DW  write data.
- wr_ready  out  1  queue can accept; high iff not full.
- rf_ready  in  1  array accepts the head write this cycle.
- WriteEnable  out  1  head entry valid; high iff queue not empty.
- WriteWordline  out  16  one-hot decode of head register ID; all zero when empty.
- WriteData  out  DW  head data; zero when empty.
- rd_reg  in  4  forwarding lookup register ID.
- fwd_hit  out  1  some pending entry targets rd_reg.
- fwd_data  out  DW  data of the youngest matching entry; zero when no hit.
- count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Push: when wr_req && wr_ready, store {wr_reg, wr_data} at the tail and advance the tail pointer.
- Pop: when WriteEnable && rf_ready, advance the head pointer.
- Push and pop in the same cycle: both happen; count is unchanged.
- Full: wr_ready is 0, including in a cycle where a pop occurs. No same-cycle pass-through slot. A wr_req while full is dropped. The upstream stage must stall; this is not an error.
- Empty: WriteEnable, WriteWordline and WriteData are all 0, and rf_ready is ignored.
- Wordline decode: bit k is set iff head wr_reg == k. Register IDs 0 and 15 decode like any other ID, with no special-casing.
- Forwarding: compare rd_reg against every valid entry.
  - fwd_hit is the OR of all matches.
  - fwd_data comes from the match closest to the tail (youngest), so repeated writes to the same register resolve to the newest value.
  - The entry popped in the current cycle still counts as pending during that cycle.
  - A push in the current cycle is not visible until the next cycle.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer equality.
- Reset, asserted at any time, empties the queue immediately. Entries in flight are discarded and no partial write reaches the array.

## Timing
- Reset values: count = 0; wr_ready = 1; WriteEnable = 0; WriteWordline = 16'h0000; WriteData = 0; fwd_hit = 0; fwd_data = 0.
- Output timing:
  - WriteEnable, WriteWordline and WriteData are combinational from head state only. They do not depend combinationally on any input.
  - fwd_hit and fwd_data are combinational from rd_reg and queue state.
  - wr_ready is combinational from count only.
- Latency: a request pushed into an empty queue at edge N appears on WriteWordline after edge N (one cycle). With rf_ready held high it is popped at edge N+1.
- Throughput: one push and one pop per cycle sustained.
- Ordering: writes reach the array strictly in push order.
- Queue content is undefined after reset; only the valid range (head to head+count-1) is observable.

## Structure
- Shared register-file package holds:
  - REG_ID_W = 4 and NUM_REGS = 16;
  - the entry struct {reg_id, data};
  - a function that decodes a register ID to a 16-bit one-hot wordline, shared with the read-port decoder so both sides decode identically.
- One natural sub-module, regfile_fwd_match: a DEPTH-way priority compare returning hit and youngest data.
- Storage, pointers and counter stay in the top module.

## Test plan
- Reset then idle: after rst is released, WriteEnable=0, WriteWordline=0000, wr_ready=1, count=0. Assert rst while the queue holds 3 entries → on the next sample count=0 and WriteWordline=0.
- Single write: push reg 5 with data 16'hBEEF, rf_ready=1 → next cycle WriteWordline=16'h0020 and WriteData=BEEF; the cycle after, WriteEnable=0.
- Fill with back-pressure: hold rf_ready=0 and push regs 1, 2, 3, 4 → count=4 and wr_ready=0. A fifth push of reg 9 is dropped. Release rf_ready → wordlines 0002, 0004, 0008, 0010 appear in order, and reg 9 never appears.
- Simultaneous push and pop when full: count=4 with rf_ready=1 and wr_req=1 → the pop happens, the push is refused, count=3.
- Forwarding: queue holds reg 7←0x1111 followed by reg 7←0x2222; set rd_reg=7 → fwd_hit=1 and fwd_data=2222. Set rd_reg=8 → fwd_hit=0 and fwd_data=0.
- Wrap-around: run 10 push/pop pairs with varying IDs 0..15, including 0 and 15 → every wordline is one-hot and matches its ID, and ordering holds across pointer wrap.
